cpu_controller: RTL
===================

# cpu_controller

Instruction-sequencing controller for the 8-bit accumulator CPU: an 8-phase state machine that fetches each instruction and drives the datapath control strobes that feed the `alu` block. The 3-bit `opcode` it decodes uses the same encoding the ALU executes, so this block issues the operations the ALU performs. It consumes the ALU's `a_is_zero` flag to resolve skip-if-zero. It sits between the instruction register and the PC/accumulator/memory strobes.

## Interface
- `HALT_STICKY`, default 1: 1 = after HLT the controller freezes until reset; 0 = halt is a one-phase pulse and sequencing continues.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `opcode` input 3: instruction register opcode; valid from phase 4 to phase 7.
  - Encoding: 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP.
- `zero` input 1: accumulator-is-zero flag, connected to ALU `a_is_zero`.
- `phase` output 3: current phase, 0..7.
- `sel` output 1: address mux selects PC (1) or IR operand (0).
- `rd` output 1: memory read enable.
- `ld_ir` output 1: load instruction register.
- `inc_pc` output 1: increment PC.
- `halt` output 1: CPU halted / halting.
- `ld_pc` output 1: load PC from IR operand.
- `data_e` output 1: drive accumulator onto data bus.
- `ld_ac` output 1: load accumulator from ALU output.
- `wr` output 1: memory write strobe.

## Operation
- **State:** 3-bit phase register plus a 1-bit `halted` flag. Outputs are combinational decode of (phase, halted, opcode, zero); no other state.
- **ALUOP** means opcode ∈ {ADD, AND, XOR, LDA}.
- **Phases and outputs** (any output not listed for a phase is 0):
  - 0 INST_ADDR: `sel`=1.
  - 1 INST_FETCH: `sel`=1, `rd`=1.
  - 2 INST_LOAD: `sel`=1, `rd`=1, `ld_ir`=1.
  - 3 IDLE: `sel`=1, `rd`=1, `ld_ir`=1.
  - 4 OP_ADDR: `halt`=(opcode==HLT); `inc_pc`=(opcode!=HLT).
  - 5 OP_FETCH: `rd`=ALUOP.
  - 6 ALU_OP: `rd`=ALUOP; `inc_pc`=(opcode==SKZ && zero); `ld_pc`=(opcode==JMP); `data_e`=(opcode==STO).
  - 7 STORE: `rd`=ALUOP; `ld_ac`=ALUOP; `ld_pc`=(opcode==JMP); `data_e`=(opcode==STO); `wr`=(opcode==STO).
- **Phase advance:** phase increments by 1 each clock and wraps 7→0, unless `halted`=1.
- **HLT with `HALT_STICKY`=1:**
  - At the clock edge ending phase 4 with opcode==HLT, `halted` sets and phase holds at 4.
  - While `halted`=1: `halt`=1, every other strobe is 0, and phase stays 4 regardless of opcode or zero.
  - Only `rst` clears `halted`.
- **HLT with `HALT_STICKY`=0:** `halted` is never set; `halt` is high for phase 4 only, and sequencing continues to phase 5.
- **`zero` sampling:** only meaningful in phase 6 for SKZ; ignored at all other times.
- **Mutual exclusion:** `wr` and `rd` are never both 1; `ld_ac` and `wr` are never both 1.

## Timing
- **Reset:** asynchronous assertion forces phase=0 and `halted`=0 immediately. Outputs then read `sel`=1, with `rd`, `ld_ir`, `inc_pc`, `halt`, `ld_pc`, `data_e`, `ld_ac`, `wr` all 0.
- **First edge after release:** the first rising edge after `rst` deasserts moves phase to 1.
- **Reset mid-instruction:** the same behaviour applies in any phase; no partial strobe survives.
- **Instruction length:** one instruction takes exactly 8 clocks.
- **Output latency:** strobes are valid from the phase-entry edge until the next edge, i.e. combinational within the cycle. `opcode`/`zero` changes inside phases 4–7 propagate to outputs in the same cycle.
- **SKZ:** `inc_pc` pulses twice, in phases 4 and 6, when taken; once when not taken.
- **JMP:** `ld_pc` is high for 2 consecutive cycles (phases 6, 7); `inc_pc` in phase 4 is overridden by the phase-7 load.

## Test plan
- **Reset:** assert `rst` mid-phase 5 → phase=0, `sel`=1, all other strobes 0 with no clock edge; release → phase 1 after one edge.
- **ADD fetch/execute** (opcode=010, `zero`=0) over 8 clocks:
  - `sel` high for phases 0–3; `ld_ir` for phases 2–3; `inc_pc` at phase 4.
  - `rd` for phases 1–3 and 5–7; `ld_ac` at phase 7; `wr`/`data_e`/`ld_pc` never asserted.
- **SKZ:**
  - opcode=001 with `zero`=1 → `inc_pc` at phases 4 and 6.
  - With `zero`=0 → `inc_pc` at phase 4 only.
  - `ld_ac`=0 throughout in both cases.
- **STO then JMP:**
  - opcode=110 → `data_e` at phases 6–7, `wr` at phase 7 only, `rd`=0 in phases 5–7.
  - opcode=111 → `ld_pc` at phases 6–7, `wr`=0.
- **HLT with `HALT_STICKY`=1:** opcode=000 at phase 4 → `halt`=1, `inc_pc`=0. After 10 more clocks: phase=4, `halt`=1, other strobes 0. Assert `rst` → phase=0, `halt`=0.
- **HLT with `HALT_STICKY`=0:** opcode=000 → `halt` high for exactly 1 cycle; phase reaches 7 then wraps to 0.

Source files
------------

// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller
//
// Instruction-sequencing controller for the 8-bit accumulator CPU. An 8-phase
// sequencer fetches each instruction (phases 0-3) and executes it (phases 4-7),
// decoding the IR opcode into the PC / accumulator / memory strobes. The opcode
// encoding is shared with the ALU.
//
// Parameters:
//   HALT_STICKY : 1 = HLT freezes the controller in phase 4 until reset,
//                 0 = HLT is a single-phase halt pulse and sequencing continues.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   opcode  in   [2:0] IR opcode, valid in phases 4-7
//   zero    in   accumulator-is-zero flag (ALU a_is_zero)
//   phase   out  [2:0] current phase 0..7
//   sel     out  address mux: 1 = PC, 0 = IR operand
//   rd      out  memory read enable
//   ld_ir   out  load instruction register
//   inc_pc  out  increment PC
//   halt    out  CPU halted / halting
//   ld_pc   out  load PC from IR operand
//   data_e  out  drive accumulator onto data bus
//   ld_ac   out  load accumulator from ALU
//   wr      out  memory write strobe
// -----------------------------------------------------------------------------
module cpu_controller #(
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic [2:0] phase,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       halt,
    output logic       ld_pc,
    output logic       data_e,
    output logic       ld_ac,
    output logic       wr
);

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    phase_t phase_q, phase_d;
    logic   halted_q, halted_d;
    logic   alu_op;

    // Next-state: free-running phase counter, frozen once a sticky HLT latches.
    always_comb begin
        phase_d  = phase_t'(phase_q + 3'd1);
        halted_d = halted_q;
        if (halted_q) begin
            phase_d = phase_q;
        end else if (HALT_STICKY && (phase_q == PH_OP_ADDR) && (opcode == OP_HLT)) begin
            halted_d = 1'b1;
            phase_d  = phase_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= PH_INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Instructions that read an operand from memory and write the accumulator.
    assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

    assign phase = phase_q;

    // Strobes are a pure decode of the current phase and IR so that opcode/zero
    // changes show up within the same cycle.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        halt   = 1'b0;
        ld_pc  = 1'b0;
        data_e = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    halt   = (opcode == OP_HLT);
                    inc_pc = (opcode != OP_HLT);
                end
                PH_OP_FETCH: begin
                    rd = alu_op;
                end
                PH_ALU_OP: begin
                    rd     = alu_op;
                    inc_pc = (opcode == OP_SKZ) && zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                PH_STORE: begin
                    rd     = alu_op;
                    ld_ac  = alu_op;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                    wr     = (opcode == OP_STO);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
